ctrl_unit: RTL and testbench



---
 rtl/ctrl_unit.sv | 111 +++++++++++
 tb/tb_ctrl_unit.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/ctrl_unit.sv
// Main control decoder: registered opcode/zero decode into datapath selects and enables.
// Optional macro CTRL_ILLEGAL_FLAG_EN adds a registered `illegal` output for undefined opcodes.
module ctrl_unit #(
  parameter int unsigned OPC_W  = 6,
  parameter int unsigned FUNC_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OPC_W-1:0]  i_code,
  input  logic              zero,
  output logic              pc_sel,
  output logic              ext_sel,
  output logic              reg_i_w_enable,
  output logic              reg_k_sel,
  output logic              reg_i_sel,
  output logic              alu_k_sel,
  output logic              ram_w_enable,
`ifdef CTRL_ILLEGAL_FLAG_EN
  output logic [FUNC_W-1:0] func_sel,
  output logic              illegal
`else
  output logic [FUNC_W-1:0] func_sel
`endif
);

  localparam logic [OPC_W-1:0] OP_ALU  = 6'b000001;
  localparam logic [OPC_W-1:0] OP_LW   = 6'b000010;
  localparam logic [OPC_W-1:0] OP_SW   = 6'b000011;
  localparam logic [OPC_W-1:0] OP_BEQ  = 6'b000100;
  localparam logic [OPC_W-1:0] OP_JUMP = 6'b000101;

  localparam logic [FUNC_W-1:0] FN_ADD  = 2'b00;
  localparam logic [FUNC_W-1:0] FN_SUB  = 2'b01;
  localparam logic [FUNC_W-1:0] FN_RTYP = 2'b10;

  logic              pc_d, ext_d, regw_d, k_d, isel_d, aluk_d, ramw_d, ill_d;
  logic [FUNC_W-1:0] func_d;

  always_comb begin
    pc_d   = 1'b0;
    ext_d  = 1'b0;
    regw_d = 1'b0;
    k_d    = 1'b0;
    isel_d = 1'b0;
    aluk_d = 1'b0;
    ramw_d = 1'b0;
    func_d = '0;
    ill_d  = 1'b0;
    case (i_code)
      OP_ALU: begin
        regw_d = 1'b1;
        k_d    = 1'b1;
        func_d = FN_RTYP;
      end
      OP_LW: begin
        ext_d  = 1'b1;
        regw_d = 1'b1;
        isel_d = 1'b1;
        aluk_d = 1'b1;
        func_d = FN_ADD;
      end
      OP_SW: begin
        ext_d  = 1'b1;
        aluk_d = 1'b1;
        ramw_d = 1'b1;
        func_d = FN_ADD;
      end
      OP_BEQ: begin
        pc_d   = zero;
        ext_d  = 1'b1;
        func_d = FN_SUB;
      end
      OP_JUMP: pc_d = 1'b1;
      default: ill_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_sel         <= 1'b0;
      ext_sel        <= 1'b0;
      reg_i_w_enable <= 1'b0;
      reg_k_sel      <= 1'b0;
      reg_i_sel      <= 1'b0;
      alu_k_sel      <= 1'b0;
      ram_w_enable   <= 1'b0;
      func_sel       <= '0;
    end else begin
      pc_sel         <= pc_d;
      ext_sel        <= ext_d;
      reg_i_w_enable <= regw_d;
      reg_k_sel      <= k_d;
      reg_i_sel      <= isel_d;
      alu_k_sel      <= aluk_d;
      ram_w_enable   <= ramw_d;
      func_sel       <= func_d;
    end
  end

`ifdef CTRL_ILLEGAL_FLAG_EN
  always_ff @(posedge clk) begin
    if (rst) illegal <= 1'b0;
    else     illegal <= ill_d;
  end
`else
  // ill_d has no consumer in this build; fold it into a dead term so lint stays quiet.
  logic unused_ill;
  assign unused_ill = ill_d;
`endif

endmodule

// File: tb/tb_ctrl_unit.sv
// Directed bench for ctrl_unit: table-driven reference model checked every cycle plus literal pins.
module tb_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] i_code;
  logic       zero;
  logic       pc_sel, ext_sel, reg_i_w_enable, reg_k_sel, reg_i_sel, alu_k_sel, ram_w_enable;
  logic [1:0] func_sel;
`ifdef CTRL_ILLEGAL_FLAG_EN
  logic       illegal;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  ctrl_unit #(.OPC_W(6), .FUNC_W(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_code         (i_code),
    .zero           (zero),
    .pc_sel         (pc_sel),
    .ext_sel        (ext_sel),
    .reg_i_w_enable (reg_i_w_enable),
    .reg_k_sel      (reg_k_sel),
    .reg_i_sel      (reg_i_sel),
    .alu_k_sel      (alu_k_sel),
    .ram_w_enable   (ram_w_enable),
`ifdef CTRL_ILLEGAL_FLAG_EN
    .func_sel       (func_sel),
    .illegal        (illegal)
`else
    .func_sel       (func_sel)
`endif
  );

  // Output vector order: pc ext regw k isel aluk ramw func[1:0]
  logic [8:0] got;
  assign got = {pc_sel, ext_sel, reg_i_w_enable, reg_k_sel, reg_i_sel,
                alu_k_sel, ram_w_enable, func_sel};

  // Decode table straight from the opcode list; index = opcode value.
  logic [8:0] table_v [6];
  initial begin
    table_v[0] = 9'b0_0_0_0_0_0_0_00;
    table_v[1] = 9'b0_0_1_1_0_0_0_10;
    table_v[2] = 9'b0_1_1_0_1_1_0_00;
    table_v[3] = 9'b0_1_0_0_0_1_1_00;
    table_v[4] = 9'b0_1_0_0_0_0_0_01;
    table_v[5] = 9'b1_0_0_0_0_0_0_00;
  end

  function automatic logic [8:0] model(input logic [5:0] c, input logic z, input logic r);
    logic [8:0] v;
    if (r) return '0;
    if (c > 6'd5) return '0;
    v = table_v[c];
    if (c == 6'd4) v[8] = z;
    return v;
  endfunction

  function automatic logic model_ill(input logic [5:0] c, input logic r);
    if (r) return 1'b0;
    return (c == 6'd0) || (c > 6'd5);
  endfunction

  logic [8:0] last_exp;

  task automatic cmp(input string name, input logic [8:0] act, input logic [8:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b required %b", name, act, req);
    end
  endtask

  task automatic step(input logic [5:0] c, input logic z, input logic r);
    i_code = c;
    zero   = z;
    rst    = r;
    @(posedge clk);
    #1;
    last_exp = model(c, z, r);
    cmp($sformatf("model op=%b z=%b rst=%b", c, z, r), got, last_exp);
    if ((got[6] & got[2]) === 1'b1) cmp("exclusive_writes", got, '0);
`ifdef CTRL_ILLEGAL_FLAG_EN
    cmp($sformatf("illegal op=%b rst=%b", c, r), {8'd0, illegal}, {8'd0, model_ill(c, r)});
`endif
  endtask

  initial begin
    rst = 1'b1; i_code = 6'b000001; zero = 1'b0;

    step(6'b000001, 1'b0, 1'b1);
    step(6'b000001, 1'b0, 1'b1);
    cmp("reset_all_zero", got, 9'b000000000);
    step(6'b000001, 1'b0, 1'b0);
    cmp("alu_literal", got, 9'b0_0_1_1_0_0_0_10);

    step(6'b000010, 1'b0, 1'b0);
    cmp("lw_literal", got, 9'b0_1_1_0_1_1_0_00);
    step(6'b000011, 1'b1, 1'b0);
    cmp("sw_literal", got, 9'b0_1_0_0_0_1_1_00);

    step(6'b000100, 1'b0, 1'b0);
    cmp("beq_z0_literal", got, 9'b0_1_0_0_0_0_0_01);
    step(6'b000100, 1'b1, 1'b0);
    cmp("beq_z1_literal", got, 9'b1_1_0_0_0_0_0_01);

    step(6'b000101, 1'b0, 1'b0);
    step(6'b000101, 1'b1, 1'b0);
    step(6'b000101, 1'b0, 1'b0);
    cmp("jump_literal", got, 9'b1_0_0_0_0_0_0_00);

    step(6'b000000, 1'b1, 1'b0);
    cmp("nop_000000_literal", got, 9'b0);
`ifdef CTRL_ILLEGAL_FLAG_EN
    cmp("illegal_000000_literal", {8'd0, illegal}, 9'd1);
`endif
    step(6'b111111, 1'b1, 1'b0);
    cmp("nop_111111_literal", got, 9'b0);

    // Reset mid-stream during a store.
    step(6'b000011, 1'b0, 1'b0);
    step(6'b000011, 1'b0, 1'b1);
    cmp("sw_reset_edge", {8'd0, ram_w_enable}, 9'd0);
    step(6'b000011, 1'b0, 1'b1);
    cmp("sw_reset_hold", {8'd0, ram_w_enable}, 9'd0);
    step(6'b000011, 1'b0, 1'b0);
    cmp("sw_resume", got, 9'b0_1_0_0_0_1_1_00);

    // Every opcode with both zero values.
    for (int unsigned op = 0; op < 64; op++) begin
      step(op[5:0], 1'b0, 1'b0);
      step(op[5:0], 1'b1, 1'b0);
    end
    for (int unsigned n = 0; n < 40; n++)
      step(6'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'(n % 13 == 5));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
